dcache_ctrl: RTL and testbench

//  Data-side responder for the MEM-stage requests latched by the EX/MEM pipeline register (MemRead/MemWrite, address, store data).

---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_sram.sv | 63 ++++++
 rtl/dcache_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the L1 data cache.
package dcache_pkg;

  localparam int unsigned NUM_LINES = 32;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned OFFSET_W  = 5;
  localparam int unsigned IDX_W     = $clog2(NUM_LINES);
  localparam int unsigned TAG_W     = ADDR_W - OFFSET_W - IDX_W;
  localparam int unsigned WORDS     = LINE_BITS / 32;
  localparam int unsigned WORD_W    = $clog2(WORDS);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StRefill    = 2'd2
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: IDX_W];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WORD_W];
  endfunction

  // Line-aligned byte address built from a tag and an index.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and data storage: one combinational read port, one clocked
// write port with per-word enables. Only valid/dirty are cleared by reset.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_W-1:0]     idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic [WORDS-1:0]     word_we,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 tag_we,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 wr_valid,
  input  logic                 dirty_we,
  input  logic                 wr_dirty
);

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_mem[idx];
  assign rd_data  = data_mem[idx];

  // Data words written individually so a store merges into the resident line.
  always_ff @(posedge clk_i) begin
    for (int w = 0; w < int'(WORDS); w++) begin
      if (word_we[w]) begin
        data_mem[idx][w*32 +: 32] <= wr_data[w*32 +: 32];
      end
    end
  end

  // Tag array carries no reset; validity is tracked separately.
  always_ff @(posedge clk_i) begin
    if (tag_we) begin
      tag_mem[idx] <= wr_tag;
    end
  end

  // Valid and dirty bits, cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (tag_we) begin
        valid_q[idx] <= wr_valid;
      end
      if (dirty_we) begin
        dirty_q[idx] <= wr_dirty;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Hits finish in the request cycle; misses stall the pipeline while the
// victim is written back (if dirty) and the line is refilled.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic                 mem_ack_i,
  input  logic [LINE_BITS-1:0] mem_data_i
);

  localparam logic [WORDS-1:0] WORD_ONE = {{(WORDS-1){1'b0}}, 1'b1};

  state_e state_q, state_d;

  logic                 mem_req_q,  mem_req_d;
  logic                 mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [WORD_W-1:0]    req_word;

  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic [WORDS-1:0]     word_we;
  logic [LINE_BITS-1:0] wr_data;
  logic                 tag_we;
  logic                 wr_valid;
  logic                 dirty_we;
  logic                 wr_dirty;

  logic                 hit;
  logic                 miss;
  logic                 ack;

  assign req_tag  = addr_tag(cpu_addr_i);
  assign req_idx  = addr_idx(cpu_addr_i);
  assign req_word = addr_word(cpu_addr_i);

  dcache_sram u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .idx      (req_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .word_we  (word_we),
    .wr_data  (wr_data),
    .tag_we   (tag_we),
    .wr_tag   (req_tag),
    .wr_valid (wr_valid),
    .dirty_we (dirty_we),
    .wr_dirty (wr_dirty)
  );

  assign hit  = cpu_req_i & rd_valid & (rd_tag == req_tag);
  assign miss = cpu_req_i & ~hit;
  // An ack only counts while a transfer is actually outstanding.
  assign ack  = mem_ack_i & mem_req_q;

  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (miss) begin
          state_d = (rd_valid & rd_dirty) ? StWriteback : StRefill;
        end
      end
      StWriteback: begin
        if (ack) begin
          state_d = StRefill;
        end
      end
      StRefill: begin
        if (ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // CPU-side outputs and array write controls.
  always_comb begin
    cpu_stall_o = 1'b0;
    cpu_data_o  = '0;
    word_we     = '0;
    wr_data     = '0;
    tag_we      = 1'b0;
    wr_valid    = 1'b0;
    dirty_we    = 1'b0;
    wr_dirty    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cpu_stall_o = miss;
        if (hit && !cpu_we_i) begin
          cpu_data_o = rd_data[{req_word, 5'b0} +: 32];
        end
        if (hit && cpu_we_i) begin
          word_we  = WORD_ONE << req_word;
          wr_data  = {WORDS{cpu_data_i}};
          dirty_we = 1'b1;
          wr_dirty = 1'b1;
        end
      end
      StWriteback: begin
        cpu_stall_o = 1'b1;
      end
      StRefill: begin
        cpu_stall_o = 1'b1;
        if (ack) begin
          word_we  = '1;
          wr_data  = mem_data_i;
          tag_we   = 1'b1;
          wr_valid = 1'b1;
          dirty_we = 1'b1;
          wr_dirty = 1'b0;
        end
      end
      default: cpu_stall_o = 1'b1;
    endcase
  end

  // Memory-side request: loaded on entry to a transfer state and held until
  // the ack, so address/data stay stable for the whole handshake.
  always_comb begin
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (state_q == StIdle && state_d == StWriteback) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b1;
      mem_addr_d = line_addr(rd_tag, req_idx);
      mem_data_d = rd_data;
    end else if (state_q != StRefill && state_d == StRefill) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = line_addr(req_tag, req_idx);
      mem_data_d = '0;
    end else if (state_q != StIdle && state_d == StIdle) begin
      mem_req_d  = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      mem_data_d = '0;
    end
  end

  // Memory-side registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat-memory reference model predicts
// load data, hit/miss and memory transfers; monitors compare as the DUT responds.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 cpu_req_i = 1'b0;
  logic                 cpu_we_i = 1'b0;
  logic [31:0]          cpu_addr_i = '0;
  logic [31:0]          cpu_data_i = '0;
  logic [31:0]          cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [31:0]          mem_addr_o;
  logic [255:0]         mem_data_o;
  logic                 mem_ack_i = 1'b0;
  logic [255:0]         mem_data_i = '0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_ack_i   (mem_ack_i),
    .mem_data_i  (mem_data_i)
  );

  typedef struct {
    bit           we;
    logic [31:0]  addr;
    logic [255:0] data;
  } mem_txn_t;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          hit;
  } cpu_exp_t;

  mem_txn_t    exp_mem[$];
  cpu_exp_t    exp_cpu[$];
  logic [31:0] flat[logic [31:0]];
  logic [31:0] dram[logic [31:0]];
  bit          m_valid[32];
  bit          m_dirty[32];
  logic [21:0] m_tag[32];

  int tests = 0;
  int fails = 0;
  int forced_lat = -1;
  bit hold_ack = 0;
  bit inject_ack = 0;
  int xfers = 0;
  int req_cycles = 0;
  int last_stall = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rd_flat(input logic [31:0] a);
    return flat.exists(a) ? flat[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_dram(input logic [31:0] a);
    return dram.exists(a) ? dram[a] : init_word(a);
  endfunction

  function automatic logic [255:0] line_from_flat(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = rd_flat(base + 32'(4 * i));
    return l;
  endfunction

  task automatic check(input bit ok, input string name, input logic [255:0] act,
                       input logic [255:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory responder plus memory-side monitor.
  bit           busy = 0;
  bit           unstable = 0;
  int           cnt = 0;
  bit           s_we;
  logic [31:0]  s_addr;
  logic [255:0] s_data;
  mem_txn_t     t;

  always @(negedge clk) begin
    if (mem_req_o) req_cycles++;
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (rst_i) begin
      busy = 0;
    end else if (inject_ack) begin
      inject_ack = 0;
      mem_ack_i = 1'b1;
    end else if (mem_req_o && !hold_ack) begin
      if (!busy) begin
        busy = 1;
        unstable = 0;
        s_we = mem_we_o;
        s_addr = mem_addr_o;
        s_data = mem_data_o;
        if (forced_lat >= 0) cnt = forced_lat;
        else cnt = ($urandom_range(0, 9) == 0) ? 25 : int'($urandom_range(0, 4));
      end else if (s_we != mem_we_o || s_addr != mem_addr_o || s_data != mem_data_o) begin
        unstable = 1;
      end
      if (cnt == 0) begin
        busy = 0;
        xfers++;
        mem_ack_i = 1'b1;
        check(!unstable, "mem_hold_stable", 256'(unstable), 0);
        if (exp_mem.size() == 0) begin
          check(0, "mem_unexpected_xfer", 256'(mem_addr_o), 0);
        end else begin
          t = exp_mem.pop_front();
          check(mem_we_o == t.we, "mem_we", 256'(mem_we_o), 256'(t.we));
          check(mem_addr_o == t.addr, "mem_addr", 256'(mem_addr_o), 256'(t.addr));
          if (t.we) check(mem_data_o == t.data, "wb_data", mem_data_o, t.data);
        end
        if (mem_we_o) begin
          for (int i = 0; i < 8; i++) dram[mem_addr_o + 32'(4 * i)] = mem_data_o[i*32 +: 32];
        end else begin
          for (int i = 0; i < 8; i++) mem_data_i[i*32 +: 32] = rd_dram(mem_addr_o + 32'(4 * i));
        end
      end else begin
        cnt--;
      end
    end
  end

  // CPU-side monitor: an access completes on the first unstalled cycle.
  int       stall_cnt = 0;
  cpu_exp_t e;

  always @(negedge clk) begin
    if (rst_i) begin
      stall_cnt = 0;
    end else if (cpu_req_i) begin
      if (cpu_stall_o) begin
        stall_cnt++;
      end else begin
        if (exp_cpu.size() == 0) begin
          check(0, "cpu_unexpected_completion", 256'(cpu_addr_i), 0);
        end else begin
          e = exp_cpu.pop_front();
          check((stall_cnt == 0) == e.hit, "hit_vs_stall", 256'(stall_cnt), 256'(e.hit));
          if (e.is_load) check(cpu_data_o == e.data, "load_data", 256'(cpu_data_o), 256'(e.data));
        end
        last_stall = stall_cnt;
        stall_cnt = 0;
      end
    end
  end

  // Predict the outcome of one access, then drive it until it completes.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] data);
    logic [4:0]  idx;
    logic [21:0] tag;
    bit          hit;
    cpu_exp_t    c;
    mem_txn_t    m;
    int          n;
    idx = addr[9:5];
    tag = addr[31:10];
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        m.we = 1;
        m.addr = {m_tag[idx], idx, 5'b0};
        m.data = line_from_flat(m.addr);
        exp_mem.push_back(m);
      end
      m.we = 0;
      m.addr = {tag, idx, 5'b0};
      m.data = '0;
      exp_mem.push_back(m);
      m_valid[idx] = 1;
      m_tag[idx] = tag;
      m_dirty[idx] = 0;
    end
    c.is_load = !we;
    c.hit = hit;
    c.data = rd_flat({addr[31:2], 2'b00});
    if (we) begin
      flat[{addr[31:2], 2'b00}] = data;
      m_dirty[idx] = 1;
    end
    exp_cpu.push_back(c);
    @(posedge clk); #1;
    cpu_req_i = 1'b1;
    cpu_we_i = we;
    cpu_addr_i = addr;
    cpu_data_i = data;
    for (n = 0; n < 600; n++) begin
      @(negedge clk);
      if (!cpu_stall_o) break;
    end
    if (n == 600) check(0, "access_timeout", 256'(addr), 0);
    @(posedge clk); #1;
    cpu_req_i = 1'b0;
  endtask

  // Reset drops dirty lines: memory then holds only what was written back.
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    flat = dram;
    exp_cpu.delete();
    exp_mem.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check(mem_req_o == 0, "reset_mem_req", 256'(mem_req_o), 0);
    check(mem_we_o == 0, "reset_mem_we", 256'(mem_we_o), 0);
    check(mem_addr_o == 0, "reset_mem_addr", 256'(mem_addr_o), 0);
    check(mem_data_o == 0, "reset_mem_data", mem_data_o, 0);
    check(cpu_stall_o == 0, "reset_stall", 256'(cpu_stall_o), 0);
    check(cpu_data_o == 0, "reset_cpu_data", 256'(cpu_data_o), 0);

    // Cold load, ack in the 10th request cycle.
    forced_lat = 9;
    access(0, 32'h0000_0040, 0);
    @(posedge clk); #1;
    check(last_stall == 11, "cold_miss_stall_cycles", 256'(last_stall), 11);

    // Store hit, then load it back.
    forced_lat = -1;
    access(1, 32'h0000_0044, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check(last_stall == 0, "store_hit_no_stall", 256'(last_stall), 0);
    access(0, 32'h0000_0044, 0);

    // Conflict miss on a dirty line: writeback 0x40 then refill 0x440.
    access(0, 32'h0000_0440, 0);
    access(0, 32'h0000_0044, 0);

    // Fixed ack latencies over clean and dirty conflict misses.
    forced_lat = 0;
    access(1, 32'h0000_0C48, 32'h1111_0000);
    forced_lat = 1;
    access(1, 32'h0000_1048, 32'h2222_0000);
    forced_lat = 25;
    access(1, 32'h0000_1448, 32'h3333_0000);
    forced_lat = -1;

    // Reset while a refill is outstanding.
    hold_ack = 1;
    @(posedge clk); #1;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h0000_1880;
    repeat (4) @(negedge clk);
    check(mem_req_o == 1, "refill_req_pending", 256'(mem_req_o), 1);
    check(mem_addr_o == 32'h0000_1880, "refill_addr_pending", 256'(mem_addr_o), 32'h1880);
    @(posedge clk); #1;
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    hold_ack = 0;
    model_reset();
    @(negedge clk);
    check(mem_req_o == 0, "req_dropped_after_reset", 256'(mem_req_o), 0);
    check(cpu_stall_o == 0, "no_stall_after_reset", 256'(cpu_stall_o), 0);
    inject_ack = 1;
    repeat (3) @(negedge clk);
    check(mem_req_o == 0, "late_ack_ignored", 256'(mem_req_o), 0);
    access(0, 32'h0000_1880, 0);

    // Prime ten lines, then alternate load/store hits with no memory traffic.
    for (int k = 0; k < 10; k++) access(0, 32'h0000_0400 | 32'((8 + k) << 5), 0);
    begin
      int rc;
      rc = req_cycles;
      for (int k = 0; k < 10; k++) begin
        access(k[0], 32'h0000_0400 | 32'((8 + k) << 5) | 32'(k[2:0] << 2), $urandom);
      end
      check(req_cycles == rc, "hits_no_mem_req", 256'(req_cycles - rc), 0);
    end

    // Random traffic over a small address window to force conflicts.
    repeat (150) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) |
          ($urandom_range(0, 7) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (5) @(posedge clk);
    check(exp_cpu.size() == 0, "cpu_queue_drained", 256'(exp_cpu.size()), 0);
    check(exp_mem.size() == 0, "mem_queue_drained", 256'(exp_mem.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
